spi_slave: RTL and testbench

SPI responder that sits on the far end of the team's SPI master link, e.g. in the loopback and peripheral-emulation builds of the DS1302 project. It oversamples nCS/DCLK/MOSI with sys_clk and supports all four CPOL/CPHA modes. Each full 8-bit MSB-first frame is delivered as a byte with a one-cycle strobe. A byte supplied by user logic is shifted out on MISO, with back-to-back bytes allowed within one nCS assertion.

---
 rtl/spi_pkg.sv | 31 +++
 rtl/spi_slave_if.sv | 29 ++
 rtl/spi_sync_edge.sv | 34 +++
 rtl/spi_slave.sv | 160 ++++++++++++++++
 tb/tb_spi_slave.sv | 253 +++++++++++++++++++++++++
 5 files changed

// File: rtl/spi_pkg.sv
// Shared definitions for the SPI responder: byte width, synchronizer depth
// and the DCLK edge decode that maps CPOL/CPHA onto sample/shift strobes.
package spi_pkg;

   localparam int SPI_BYTE_W      = 8;
   localparam int SPI_SYNC_STAGES = 2;

   typedef struct packed {
      logic sample;
      logic shift;
   } spi_edge_t;

   // A DCLK edge that lands away from CPOL is the leading edge, one that lands
   // back on CPOL is the trailing edge. CPHA picks which of the two samples.
   function automatic spi_edge_t spi_edge_decode(
      input logic cpol,
      input logic cpha,
      input logic dclk_lvl,
      input logic dclk_edge
   );
      spi_edge_t d;
      logic      leading;
      logic      trailing;
      leading  = dclk_edge & (dclk_lvl != cpol);
      trailing = dclk_edge & (dclk_lvl == cpol);
      d.sample = cpha ? trailing : leading;
      d.shift  = cpha ? leading  : trailing;
      return d;
   endfunction

endpackage

// File: rtl/spi_slave_if.sv
// Pin and user-side bundle of the SPI responder. The master modport is the
// view of whatever drives the link and feeds tx_data; slave is the responder.
interface spi_slave_if;
   import spi_pkg::*;

   logic                  nCS;
   logic                  DCLK;
   logic                  MOSI;
   logic                  MISO;
   logic                  CPOL;
   logic                  CPHA;
   logic [SPI_BYTE_W-1:0] tx_data;
   logic                  tx_ack;
   logic [SPI_BYTE_W-1:0] rx_data;
   logic                  rx_valid;
   logic                  busy;
   logic                  frame_err;

   modport slave (
      input  nCS, DCLK, MOSI, CPOL, CPHA, tx_data,
      output MISO, tx_ack, rx_data, rx_valid, busy, frame_err
   );

   modport master (
      output nCS, DCLK, MOSI, CPOL, CPHA, tx_data,
      input  MISO, tx_ack, rx_data, rx_valid, busy, frame_err
   );

endinterface

// File: rtl/spi_sync_edge.sv
// Multi-flop synchronizer for an asynchronous pin plus one delay flop for
// rise/fall detection on the synchronized level.
module spi_sync_edge
   import spi_pkg::*;
#(
   parameter logic RST_VAL = 1'b0
) (
   input  logic sys_clk,
   input  logic rst,
   input  logic din,
   output logic sync,
   output logic rise,
   output logic fall
);

   logic [SPI_SYNC_STAGES-1:0] sync_q;
   logic                       dly_q;

   // Synchronizer chain and edge-detect delay flop.
   always_ff @(posedge sys_clk) begin
      if (rst) begin
         sync_q <= {SPI_SYNC_STAGES{RST_VAL}};
         dly_q  <= RST_VAL;
      end else begin
         sync_q <= {sync_q[SPI_SYNC_STAGES-2:0], din};
         dly_q  <= sync_q[SPI_SYNC_STAGES-1];
      end
   end

   assign sync = sync_q[SPI_SYNC_STAGES-1];
   assign rise = sync & ~dly_q;
   assign fall = ~sync & dly_q;

endmodule

// File: rtl/spi_slave.sv
// SPI responder: oversamples nCS/DCLK/MOSI on sys_clk, supports all four
// CPOL/CPHA modes, delivers MSB-first bytes with a one-cycle strobe and shifts
// out user bytes on MISO, back to back within one nCS window.
// Optional build macro: SPI_SLAVE_FRAME_ERR_EN enables the frame_err pulse on
// nCS rising mid-byte; without it frame_err is tied low.
module spi_slave
   import spi_pkg::*;
(
   input  logic       sys_clk,
   input  logic       rst,
   spi_slave_if.slave bus
);

   logic                       ncs_sync;
   logic                       ncs_rise;
   logic                       ncs_fall;
   logic                       dclk_sync;
   logic                       dclk_rise;
   logic                       dclk_fall;
   logic [SPI_SYNC_STAGES-1:0] mosi_q;
   logic                       mosi_sync;

   logic [1:0]                 settle_cnt;
   logic                       armed;

   spi_edge_t                  dclk_dec;
   logic                       spi_active;
   logic                       sample_en;
   logic                       shift_en;
   logic                       last_bit;
   logic                       ncs_start;
   logic                       ncs_stop;

   logic [2:0]                 bit_cnt;
   logic [SPI_BYTE_W-1:0]      rx_shift;
   logic [SPI_BYTE_W-1:0]      tx_shift;
   logic [SPI_BYTE_W-1:0]      rx_data_q;
   logic                       rx_valid_q;
   logic                       tx_ack_q;

   spi_sync_edge #(.RST_VAL(1'b1)) u_ncs_sync (
      .sys_clk (sys_clk),
      .rst     (rst),
      .din     (bus.nCS),
      .sync    (ncs_sync),
      .rise    (ncs_rise),
      .fall    (ncs_fall)
   );

   spi_sync_edge #(.RST_VAL(1'b0)) u_dclk_sync (
      .sys_clk (sys_clk),
      .rst     (rst),
      .din     (bus.DCLK),
      .sync    (dclk_sync),
      .rise    (dclk_rise),
      .fall    (dclk_fall)
   );

   // MOSI only needs a level, so it gets a bare synchronizer with the same
   // depth as DCLK to keep data and clock aligned.
   always_ff @(posedge sys_clk) begin
      if (rst) begin
         mosi_q <= '0;
      end else begin
         mosi_q <= {mosi_q[SPI_SYNC_STAGES-2:0], bus.MOSI};
      end
   end

   assign mosi_sync = mosi_q[SPI_SYNC_STAGES-1];

   // After reset the nCS synchronizer holds its reset level until the pin has
   // propagated through; a down-counter waits that out, and the link only arms
   // once a genuine nCS-high has been seen, so a transfer caught mid-flight by
   // reset is ignored until the next real falling edge.
   always_ff @(posedge sys_clk) begin
      if (rst) begin
         settle_cnt <= 2'(SPI_SYNC_STAGES);
         armed      <= 1'b0;
      end else begin
         if (settle_cnt != 2'd0) begin
            settle_cnt <= settle_cnt - 2'd1;
         end
         if ((settle_cnt == 2'd0) && ncs_sync) begin
            armed <= 1'b1;
         end
      end
   end

   // Edge decode and qualification; the nCS-rise cycle still accepts a DCLK
   // edge so a byte finishing together with nCS rising is not lost.
   always_comb begin
      dclk_dec   = spi_edge_decode(bus.CPOL, bus.CPHA, dclk_sync, dclk_rise | dclk_fall);
      ncs_start  = armed & ncs_fall;
      ncs_stop   = armed & ncs_rise;
      spi_active = armed & ~ncs_fall & (~ncs_sync | ncs_rise);
      sample_en  = spi_active & dclk_dec.sample;
      shift_en   = spi_active & dclk_dec.shift & (bit_cnt != 3'd0);
      last_bit   = sample_en & (bit_cnt == 3'd7);
   end

   // Receive/transmit shifters, bit counter and the byte/ack strobes.
   always_ff @(posedge sys_clk) begin
      if (rst) begin
         bit_cnt    <= 3'd0;
         rx_shift   <= '0;
         tx_shift   <= '0;
         rx_data_q  <= '0;
         rx_valid_q <= 1'b0;
         tx_ack_q   <= 1'b0;
      end else begin
         rx_valid_q <= last_bit;
         tx_ack_q   <= ncs_start | last_bit;

         if (last_bit) begin
            rx_data_q <= {rx_shift[SPI_BYTE_W-2:0], mosi_sync};
         end

         if (ncs_start || ncs_stop) begin
            bit_cnt  <= 3'd0;
            rx_shift <= '0;
         end else if (sample_en) begin
            bit_cnt  <= bit_cnt + 3'd1;
            rx_shift <= {rx_shift[SPI_BYTE_W-2:0], mosi_sync};
         end

         // A shift edge right after a load is suppressed via shift_en so the
         // freshly loaded MSB stays on MISO for the master's next sample.
         if (ncs_start || last_bit) begin
            tx_shift <= bus.tx_data;
         end else if (shift_en) begin
            tx_shift <= {tx_shift[SPI_BYTE_W-2:0], 1'b0};
         end
      end
   end

`ifdef SPI_SLAVE_FRAME_ERR_EN
   logic frame_err_q;

   // Flag nCS rising with a partial byte; a byte completing on that same
   // cycle is a clean end of frame.
   always_ff @(posedge sys_clk) begin
      if (rst) begin
         frame_err_q <= 1'b0;
      end else begin
         frame_err_q <= ncs_stop & (bit_cnt != 3'd0) & ~last_bit;
      end
   end

   assign bus.frame_err = frame_err_q;
`else
   assign bus.frame_err = 1'b0;
`endif

   assign bus.busy     = ~ncs_sync;
   assign bus.MISO     = ~ncs_sync ? tx_shift[SPI_BYTE_W-1] : 1'b0;
   assign bus.rx_data  = rx_data_q;
   assign bus.rx_valid = rx_valid_q;
   assign bus.tx_ack   = tx_ack_q;

endmodule

// File: tb/tb_spi_slave.sv
// Bench for spi_slave: a bit-banged SPI master drives directed bytes, expected
// received bytes go into a queue that a monitor drains on every rx_valid, and
// the monitor also feeds the next tx_data on each tx_ack.
module tb_spi_slave;

   localparam int H = 6;
`ifdef SPI_SLAVE_FRAME_ERR_EN
   localparam int FE_EXP = 1;
`else
   localparam int FE_EXP = 0;
`endif

   logic sys_clk;
   logic rst;

   spi_slave_if bus();

   spi_slave u_dut (
      .sys_clk (sys_clk),
      .rst     (rst),
      .bus     (bus)
   );

   int         checks  = 0;
   int         errors  = 0;
   int         ack_cnt = 0;
   int         fe_cnt  = 0;
   logic [7:0] exp_rx[$];
   logic [7:0] tx_next[$];

   initial begin
      sys_clk = 1'b0;
      forever #5 sys_clk = ~sys_clk;
   end

   task automatic cyc(input int n);
      repeat (n) @(negedge sys_clk);
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic set_mode(input logic p, input logic h);
      bus.CPOL = p;
      bus.CPHA = h;
      bus.DCLK = p;
      cyc(8);
   endtask

   task automatic cs_low();
      bus.nCS = 1'b0;
      cyc(H);
   endtask

   task automatic cs_high();
      cyc(H);
      bus.nCS = 1'b1;
      cyc(12);
   endtask

   // Master side of nbits bits; stable drops if MISO moves between the
   // master's sample edge and the following shift edge (except after the
   // last bit of a byte, where the next byte is reloaded).
   task automatic xfer_bits(input logic [7:0] mo, input int nbits,
                            output logic [7:0] mi, output logic stable);
      mi     = 8'h00;
      stable = 1'b1;
      for (int k = 0; k < nbits; k++) begin
         int i;
         i = 7 - k;
         if (!bus.CPHA) begin
            bus.MOSI = mo[i];
            cyc(H);
            bus.DCLK = ~bus.CPOL;
            mi[i]    = bus.MISO;
            for (int c = 0; c < H; c++) begin
               cyc(1);
               if (i != 0 && bus.MISO !== mi[i]) stable = 1'b0;
            end
            bus.DCLK = bus.CPOL;
         end else begin
            bus.DCLK = ~bus.CPOL;
            bus.MOSI = mo[i];
            cyc(H);
            bus.DCLK = bus.CPOL;
            mi[i]    = bus.MISO;
            for (int c = 0; c < H; c++) begin
               cyc(1);
               if (i != 0 && bus.MISO !== mi[i]) stable = 1'b0;
            end
         end
      end
   endtask

   // Monitor: scoreboard for rx_valid, tx_data feed on tx_ack, frame_err count.
   initial begin
      logic [7:0] exp;
      forever begin
         @(negedge sys_clk);
         if (bus.rx_valid === 1'b1) begin
            if (exp_rx.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL rx_unexpected: got %0h expected no byte", bus.rx_data);
            end else begin
               exp = exp_rx.pop_front();
               check("rx_data", {24'h0, bus.rx_data}, {24'h0, exp});
            end
         end
         if (bus.tx_ack === 1'b1) begin
            ack_cnt++;
            if (tx_next.size() > 0) bus.tx_data = tx_next.pop_front();
         end
         if (bus.frame_err === 1'b1) fe_cnt++;
      end
   end

   initial begin
      logic [7:0] mi;
      logic       st;
      int         ab;
      int         fb;

      rst         = 1'b1;
      bus.nCS     = 1'b1;
      bus.DCLK    = 1'b0;
      bus.MOSI    = 1'b0;
      bus.CPOL    = 1'b0;
      bus.CPHA    = 1'b0;
      bus.tx_data = 8'h00;
      cyc(5);
      rst = 1'b0;
      cyc(1);
      check("rst_miso",      bus.MISO,      0);
      check("rst_tx_ack",    bus.tx_ack,    0);
      check("rst_rx_data",   bus.rx_data,   0);
      check("rst_rx_valid",  bus.rx_valid,  0);
      check("rst_busy",      bus.busy,      0);
      check("rst_frame_err", bus.frame_err, 0);
      cyc(5);

      // Mode 0 single byte.
      set_mode(1'b0, 1'b0);
      bus.tx_data = 8'h3C;
      ab = ack_cnt;
      exp_rx.push_back(8'hA5);
      cs_low();
      check("m0_ack_at_fall", ack_cnt - ab, 1);
      check("m0_busy", bus.busy, 1);
      xfer_bits(8'hA5, 8, mi, st);
      check("m0_master_rx", mi, 8'h3C);
      check("m0_miso_stable", st, 1);
      cs_high();
      check("m0_rx_pending", exp_rx.size(), 0);
      check("m0_ack_total", ack_cnt - ab, 2);
      check("m0_rx_hold", bus.rx_data, 8'hA5);

      // Modes 1..3.
      for (int m = 1; m < 4; m++) begin
         set_mode(m[1], m[0]);
         bus.tx_data = 8'h7E;
         exp_rx.push_back(8'h81);
         cs_low();
         xfer_bits(8'h81, 8, mi, st);
         check($sformatf("mode%0d_master_rx", m), mi, 8'h7E);
         check($sformatf("mode%0d_miso_stable", m), st, 1);
         cs_high();
         check($sformatf("mode%0d_rx_pending", m), exp_rx.size(), 0);
      end

      // Back-to-back bytes with tx_data refreshed on each tx_ack.
      set_mode(1'b0, 1'b0);
      bus.tx_data = 8'hF0;
      tx_next.push_back(8'hF1);
      tx_next.push_back(8'hF2);
      ab = ack_cnt;
      cs_low();
      for (int b = 0; b < 3; b++) begin
         exp_rx.push_back(8'(b + 1));
         xfer_bits(8'(b + 1), 8, mi, st);
         check($sformatf("b2b%0d_master_rx", b), mi, 32'(8'hF0 + b));
      end
      cs_high();
      check("b2b_rx_pending", exp_rx.size(), 0);
      check("b2b_ack_total", ack_cnt - ab, 4);

      // Partial byte then a full one.
      fb = fe_cnt;
      cs_low();
      xfer_bits(8'hB7, 5, mi, st);
      cs_high();
      check("partial_frame_err", fe_cnt - fb, FE_EXP);
      exp_rx.push_back(8'hC3);
      cs_low();
      xfer_bits(8'hC3, 8, mi, st);
      cs_high();
      check("partial_rx_pending", exp_rx.size(), 0);
      check("partial_next_rx", bus.rx_data, 8'hC3);
      check("partial_fe_total", fe_cnt - fb, FE_EXP);

      // Reset in the middle of a byte.
      cs_low();
      xfer_bits(8'h96, 4, mi, st);
      rst = 1'b1;
      cyc(1);
      rst = 1'b0;
      check("midrst_miso",      bus.MISO,      0);
      check("midrst_tx_ack",    bus.tx_ack,    0);
      check("midrst_rx_data",   bus.rx_data,   0);
      check("midrst_rx_valid",  bus.rx_valid,  0);
      check("midrst_busy",      bus.busy,      0);
      check("midrst_frame_err", bus.frame_err, 0);
      ab = ack_cnt;
      fb = fe_cnt;
      xfer_bits(8'h60, 4, mi, st);
      cs_high();
      check("midrst_ignored_ack", ack_cnt - ab, 0);
      check("midrst_ignored_fe", fe_cnt - fb, 0);
      exp_rx.push_back(8'h5A);
      bus.tx_data = 8'h3C;
      cs_low();
      xfer_bits(8'h5A, 8, mi, st);
      cs_high();
      check("postrst_rx_pending", exp_rx.size(), 0);
      check("postrst_rx_data", bus.rx_data, 8'h5A);
      check("postrst_master_rx", mi, 8'h3C);

      // DCLK activity with nCS high.
      ab = ack_cnt;
      st = 1'b1;
      for (int e = 0; e < 16; e++) begin
         bus.DCLK = ~bus.DCLK;
         bus.MOSI = e[0];
         for (int c = 0; c < H; c++) begin
            cyc(1);
            if (bus.MISO !== 1'b0 || bus.busy !== 1'b0) st = 1'b0;
         end
      end
      check("idle_miso_busy_low", st, 1);
      check("idle_no_ack", ack_cnt - ab, 0);
      cyc(10);
      check("final_rx_pending", exp_rx.size(), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
